// File: rtl/bg_tile_renderer_pkg.sv
// Shared constants, tile-word layout and pipeline tag types for the background tile renderer.
`timescale 1ns/1ps
package bg_pkg;
   localparam int TILE_W    = 16;
   localparam int TILE_H    = 16;
   localparam int TILE_COLS = 40;
   localparam int TILE_ROWS = 30;
   localparam int SCREEN_W  = 640;
   localparam int SCREEN_H  = 480;
   localparam int PIPE_LAT  = 4;

   localparam int TW_COL_LSB = 0;
   localparam int TW_ROW_LSB = 3;
   localparam int TW_XFLIP   = 6;
   localparam int TW_YFLIP   = 7;
   localparam int TW_EN      = 8;

   typedef struct packed {
      logic       en;
      logic       y_flip;
      logic       x_flip;
      logic [2:0] row;
      logic [2:0] col;
   } tile_word_t;

   typedef struct packed {
      logic       valid;
      logic [9:0] x;
      logic [9:0] y;
   } pix_tag_t;

   function automatic tile_word_t decode_tile(input logic [8:0] w);
      tile_word_t t;
      t.col    = w[TW_COL_LSB +: 3];
      t.row    = w[TW_ROW_LSB +: 3];
      t.x_flip = w[TW_XFLIP];
      t.y_flip = w[TW_YFLIP];
      t.en     = w[TW_EN];
      return t;
   endfunction
endpackage

// File: rtl/bg_tile_renderer_if.sv
// Memory-side bus of the renderer: tile-map RAM port B and sprite-sheet ROM.
`timescale 1ns/1ps
interface bg_tile_renderer_if;
   // en qualifies addr for one cycle; data returns one clock later. No ready, no back-pressure.
   logic        tile_ram_en;
   logic [15:0] tile_ram_addr;
   logic [31:0] tile_ram_data;
   logic        sheet_en;
   logic [13:0] sheet_addr;
   logic [11:0] sheet_data;

   modport master (
      output tile_ram_en, tile_ram_addr, sheet_en, sheet_addr,
      input  tile_ram_data, sheet_data
   );

   modport slave (
      input  tile_ram_en, tile_ram_addr, sheet_en, sheet_addr,
      output tile_ram_data, sheet_data
   );
endinterface

// File: rtl/bg_tile_addr.sv
// Scroll wrap and tile-map index: xs = (x + offset) mod 640, index = row*40 + col.
`timescale 1ns/1ps
module bg_tile_addr
   import bg_pkg::*;
(
   input  logic [9:0]  x,
   input  logic [9:0]  y,
   input  logic [3:0]  x_offset,
   output logic [15:0] tile_addr,
   output logic [3:0]  px,
   output logic [3:0]  py
);
   logic [10:0] xs_raw;
   logic [10:0] xs;
   logic [5:0]  col;
   logic [4:0]  row;
   logic        unused_bits;

   assign xs_raw = {1'b0, x} + {7'd0, x_offset};
   assign xs     = (xs_raw >= 11'(SCREEN_W)) ? xs_raw - 11'(SCREEN_W) : xs_raw;
   assign col    = xs[9:4];
   assign row    = y[8:4];
   assign px     = xs[3:0];
   assign py     = y[3:0];

   assign tile_addr   = 16'(row) * 16'(TILE_COLS) + 16'(col);
   assign unused_bits = ^{xs[10], y[9]};
endmodule

// File: rtl/bg_tile_renderer.sv
// Background tile renderer: 4-stage pixel pipeline, one pixel per clock, no stalls.
// Optional `BG_TRANSPARENCY_EN: sheet pixels equal to COLOR_KEY fall through to the backdrop.
`timescale 1ns/1ps
module bg_tile_renderer
   import bg_pkg::*;
#(
   parameter logic [11:0] BACKDROP_RGB = 12'h000,
   parameter logic [11:0] COLOR_KEY    = 12'hF0F
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      video_on,
   input  logic [9:0]                x,
   input  logic [9:0]                y,
   input  logic [3:0]                bg_x_offset,
   bg_tile_renderer_if.master        mem,
   output logic [11:0]               rgb,
   output logic                      bg_hit,
   output logic                      pixel_valid,
   output logic [9:0]                out_x,
   output logic [9:0]                out_y
);
   logic [15:0] addr_c;
   logic [3:0]  px_c, py_c;
   logic        vis_c;
   pix_tag_t    a_tag, b_tag, c_tag, d_tag;
   logic [3:0]  a_px, a_py, b_px, b_py;
   tile_word_t  tw;
   logic [3:0]  fx, fy;
   logic        d_draw;
   logic        opaque;
   logic [11:0] rgb_c;
   logic        unused_tile_bits;

   bg_tile_addr u_addr (
      .x         (x),
      .y         (y),
      .x_offset  (bg_x_offset),
      .tile_addr (addr_c),
      .px        (px_c),
      .py        (py_c)
   );

   assign vis_c = video_on & (y < 10'(SCREEN_H));

   // Stage A: tile-map request
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mem.tile_ram_addr <= '0;
         mem.tile_ram_en   <= 1'b0;
         a_tag             <= '0;
         a_px              <= '0;
         a_py              <= '0;
      end else begin
         mem.tile_ram_addr <= addr_c;
         mem.tile_ram_en   <= vis_c;
         a_tag             <= '{valid: vis_c, x: x, y: y};
         a_px              <= px_c;
         a_py              <= py_c;
      end
   end

   // Stage B: RAM read in progress
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         b_tag <= '0;
         b_px  <= '0;
         b_py  <= '0;
      end else begin
         b_tag <= a_tag;
         b_px  <= a_px;
         b_py  <= a_py;
      end
   end

   // Stage C: flips mirror within the 16x16 cell, so 15-p is just the bitwise inverse
   assign tw = decode_tile(mem.tile_ram_data[8:0]);
   assign fx = tw.x_flip ? ~b_px : b_px;
   assign fy = tw.y_flip ? ~b_py : b_py;
   assign unused_tile_bits = ^mem.tile_ram_data[31:9];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mem.sheet_addr <= '0;
         mem.sheet_en   <= 1'b0;
         c_tag          <= '0;
      end else begin
         mem.sheet_addr <= {tw.row, fy, tw.col, fx};
         mem.sheet_en   <= b_tag.valid & tw.en;
         c_tag          <= b_tag;
      end
   end

   // Stage D: ROM read in progress
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         d_tag  <= '0;
         d_draw <= 1'b0;
      end else begin
         d_tag  <= c_tag;
         d_draw <= mem.sheet_en;
      end
   end

`ifdef BG_TRANSPARENCY_EN
   assign opaque = d_draw & (mem.sheet_data != COLOR_KEY);
`else
   assign opaque = d_draw;
   logic unused_key;
   assign unused_key = ^COLOR_KEY;
`endif

   always_comb begin
      rgb_c = 12'h000;
      if (d_tag.valid) begin
         rgb_c = opaque ? mem.sheet_data : BACKDROP_RGB;
      end
   end

   // Stage E: output register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rgb         <= '0;
         bg_hit      <= 1'b0;
         pixel_valid <= 1'b0;
         out_x       <= '0;
         out_y       <= '0;
      end else begin
         rgb         <= rgb_c;
         bg_hit      <= opaque;
         pixel_valid <= d_tag.valid;
         out_x       <= d_tag.x;
         out_y       <= d_tag.y;
      end
   end
endmodule

// File: tb/tb_bg_tile_renderer.sv
// Bench for bg_tile_renderer: behavioural tile/sheet model, per-cycle compare, directed pins.
`timescale 1ns/1ps
module tb_bg_tile_renderer;
   import bg_pkg::*;

   localparam logic [11:0] BACKDROP = 12'h5A3;
   localparam logic [11:0] KEY      = 12'hF0F;

   // clock / reset
   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       video_on = 1'b0;
   logic [9:0] x = '0;
   logic [9:0] y = '0;
   logic [3:0] bg_x_offset = '0;
   logic [11:0] rgb;
   logic        bg_hit, pixel_valid;
   logic [9:0]  out_x, out_y;
   bit          rel_req = 1'b0;

   always #5 clk = ~clk;

   bg_tile_renderer_if mem ();

   bg_tile_renderer #(.BACKDROP_RGB(BACKDROP), .COLOR_KEY(KEY)) dut (
      .clk         (clk),
      .reset       (reset),
      .video_on    (video_on),
      .x           (x),
      .y           (y),
      .bg_x_offset (bg_x_offset),
      .mem         (mem),
      .rgb         (rgb),
      .bg_hit      (bg_hit),
      .pixel_valid (pixel_valid),
      .out_x       (out_x),
      .out_y       (out_y)
   );

   // memories behind the bus
   logic [31:0] tile_ram [0:1199];
   logic [11:0] sheet_rom [0:16383];

   always @(posedge clk) begin
      if (mem.tile_ram_en)
         mem.tile_ram_data <= (mem.tile_ram_addr < 16'd1200) ? tile_ram[mem.tile_ram_addr[10:0]] : 32'hDEAD_BEEF;
      if (mem.sheet_en)
         mem.sheet_data <= sheet_rom[mem.sheet_addr];
   end

   // scoreboard
   typedef struct {
      bit         vis;
      logic [9:0] x;
      logic [9:0] y;
      int         taddr;
      bit         sen;
      int         saddr;
      logic [11:0] rgb;
      bit         hit;
   } exp_t;

   exp_t exp_q[$];
   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
      end
   endtask

   function automatic exp_t model(bit vo, logic [9:0] mx, logic [9:0] my, logic [3:0] off);
      exp_t e;
      int xs, col, row, px, py, tcol, trow, fx, fy;
      logic [31:0] w;
      e.vis = vo && (my < 10'd480);
      e.x = mx; e.y = my;
      e.taddr = 0; e.sen = 0; e.saddr = 0; e.rgb = 12'h000; e.hit = 0;
      if (e.vis) begin
         xs  = (int'(mx) + int'(off)) % 640;
         col = xs / 16;  px = xs % 16;
         row = int'(my) / 16;  py = int'(my) % 16;
         e.taddr = row * 40 + col;
         w    = tile_ram[e.taddr];
         tcol = int'(w % 8);
         trow = int'((w / 8) % 8);
         fx   = w[6] ? 15 - px : px;
         fy   = w[7] ? 15 - py : py;
         e.sen = w[8];
         e.rgb = BACKDROP;
         if (e.sen) begin
            e.saddr = (trow * 16 + fy) * 128 + tcol * 16 + fx;
            e.rgb   = sheet_rom[e.saddr];
            e.hit   = 1;
`ifdef BG_TRANSPARENCY_EN
            if (e.rgb == KEY) begin
               e.rgb = BACKDROP;
               e.hit = 0;
            end
`endif
         end
      end
      return e;
   endfunction

   // compare process: every negedge
   always @(negedge clk) begin
      int n;
      exp_t e;
      n = exp_q.size();
      if (!reset) begin
         chk("rst_rgb", 32'(rgb), 0);
         chk("rst_hit", 32'(bg_hit), 0);
         chk("rst_valid", 32'(pixel_valid), 0);
         chk("rst_out_xy", {12'd0, out_x, out_y}, 0);
         chk("rst_tile", {15'd0, mem.tile_ram_en, mem.tile_ram_addr}, 0);
         chk("rst_sheet", {17'd0, mem.sheet_en, mem.sheet_addr}, 0);
      end else begin
         if (n >= 1) begin
            e = exp_q[n-1];
            chk("tile_en", 32'(mem.tile_ram_en), 32'(e.vis));
            if (e.vis) chk("tile_addr", 32'(mem.tile_ram_addr), e.taddr);
         end else chk("tile_en", 32'(mem.tile_ram_en), 0);
         if (n >= 3) begin
            e = exp_q[n-3];
            chk("sheet_en", 32'(mem.sheet_en), 32'(e.sen));
            if (e.sen) chk("sheet_addr", 32'(mem.sheet_addr), e.saddr);
         end else chk("sheet_en", 32'(mem.sheet_en), 0);
         if (n >= PIPE_LAT + 1) begin
            e = exp_q[n-PIPE_LAT-1];
            chk("pixel_valid", 32'(pixel_valid), 32'(e.vis));
            chk("rgb", 32'(rgb), 32'(e.rgb));
            chk("bg_hit", 32'(bg_hit), 32'(e.hit));
            chk("out_x", 32'(out_x), 32'(e.x));
            chk("out_y", 32'(out_y), 32'(e.y));
         end else begin
            chk("warm_valid", 32'(pixel_valid), 0);
            chk("warm_rgb", 32'(rgb), 0);
            chk("warm_out_xy", {12'd0, out_x, out_y}, 0);
         end
      end
   end

   // driver tasks
   task automatic drive(input bit vo, input logic [9:0] dx, input logic [9:0] dy, input logic [3:0] off);
      @(negedge clk);
      #1;
      if (rel_req) begin
         reset   = 1'b1;
         rel_req = 1'b0;
      end
      video_on    = vo;
      x           = dx;
      y           = dy;
      bg_x_offset = off;
      if (reset) begin
         exp_q.push_back(model(vo, dx, dy, off));
         if (exp_q.size() > PIPE_LAT + 1) exp_q.delete(0);
      end
   endtask

   task automatic idle();
      drive(1'b0, 10'($urandom_range(0, 1023)), 10'($urandom_range(0, 1023)), 4'($urandom));
   endtask

   // -1 skips a field
   task automatic pin(input bit vo, input int px_, input int py_, input int off,
                      input int t_en, input int t_addr, input int s_en, input int s_addr,
                      input int e_rgb, input int e_hit, input int e_valid);
      drive(vo, 10'(px_), 10'(py_), 4'(off));
      idle();
      if (t_en >= 0)   chk("pin_tile_en", 32'(mem.tile_ram_en), t_en);
      if (t_addr >= 0) chk("pin_tile_addr", 32'(mem.tile_ram_addr), t_addr);
      idle(); idle();
      if (s_en >= 0)   chk("pin_sheet_en", 32'(mem.sheet_en), s_en);
      if (s_addr >= 0) chk("pin_sheet_addr", 32'(mem.sheet_addr), s_addr);
      idle(); idle();
      if (e_rgb >= 0)   chk("pin_rgb", 32'(rgb), e_rgb);
      if (e_hit >= 0)   chk("pin_hit", 32'(bg_hit), e_hit);
      if (e_valid >= 0) chk("pin_valid", 32'(pixel_valid), e_valid);
   endtask

   task automatic random_stream(input int cycles);
      logic [9:0] rx, ry;
      logic [3:0] off;
      rx = 10'($urandom_range(0, 639));
      ry = 10'($urandom_range(0, 524));
      off = 4'($urandom);
      for (int i = 0; i < cycles; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            rx = 10'($urandom_range(0, 639));
            ry = 10'($urandom_range(0, 524));
         end else if (rx == 10'd639) begin
            rx = 10'd0;
            ry = (ry == 10'd524) ? 10'd0 : ry + 10'd1;
         end else begin
            rx = rx + 10'd1;
         end
         if ($urandom_range(0, 7) == 0) off = 4'($urandom);
         drive($urandom_range(0, 9) != 0, rx, ry, off);
      end
   endtask

   initial begin
      for (int i = 0; i < 1200; i++) tile_ram[i] = $urandom;
      for (int i = 0; i < 16384; i++)
         sheet_rom[i] = ($urandom_range(0, 7) == 0) ? KEY : 12'($urandom);
      tile_ram[0]      = 32'h1F1;
      tile_ram[1]      = 32'h031;
      sheet_rom[14239] = 12'h4C7;
      sheet_rom[13980] = KEY;

      repeat (3) idle();
      rel_req = 1'b1;
      repeat (3) idle();

      // x=0,y=0 on tile 0x1F1: both flips -> fx=fy=15 -> sheet (6*16+15)*128+16+15
      pin(1, 0, 0, 0, 1, 0, 1, 14239, 12'h4C7, 1, 1);
      // px=3, py=2 on tile 0x1F1
`ifdef BG_TRANSPARENCY_EN
      pin(1, 3, 2, 0, 1, 0, 1, 13980, int'(BACKDROP), 0, 1);
`else
      pin(1, 3, 2, 0, 1, 0, 1, 13980, int'(KEY), 1, 1);
`endif
      // disabled tile 0x031
      pin(1, 16, 0, 0, 1, 1, 0, -1, int'(BACKDROP), 0, 1);
      // bottom-right corner and the scroll seam
      pin(1, 639, 479, 0, 1, 1199, -1, -1, -1, -1, 1);
      pin(1, 639, 479, 15, 1, 1160, -1, -1, -1, -1, 1);
      // below the visible area, and video_on low
      pin(1, 100, 480, 0, 0, -1, 0, -1, 0, 0, 0);
      pin(0, 100, 100, 0, 0, -1, 0, -1, 0, 0, 0);

      random_stream(3000);

      // asynchronous reset in the middle of the stream
      @(posedge clk);
      #2;
      reset = 1'b0;
      exp_q.delete();
      #1;
      chk("async_rgb", 32'(rgb), 0);
      chk("async_hit", 32'(bg_hit), 0);
      chk("async_valid", 32'(pixel_valid), 0);
      chk("async_out_xy", {12'd0, out_x, out_y}, 0);
      chk("async_tile", {15'd0, mem.tile_ram_en, mem.tile_ram_addr}, 0);
      chk("async_sheet", {17'd0, mem.sheet_en, mem.sheet_addr}, 0);
      random_stream(3);
      rel_req = 1'b1;
      random_stream(1500);

      // engine rewrites part of the map while the pipeline is idle
      repeat (8) idle();
      for (int i = 0; i < 60; i++) tile_ram[$urandom_range(0, 1199)] = $urandom;
      random_stream(1500);
      repeat (8) idle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
